// File: rtl/show_box_overlay.sv
// show_box_overlay
//   Draws up to four rectangular border boxes onto a 24-bit RGB pixel stream.
//   Box parameters are written into shadow registers at any time. They are
//   copied into the active set on a frame-start pixel, so a frame is always
//   drawn with one consistent set of boxes.
//
// Ports
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   i_valid/i_data/i_sof : input pixel stream (gaps allowed, no backpressure)
//   box_wr/box_idx/box_en/box_x0..y1/box_color : shadow box write port
//   o_valid/o_data/o_sof : output stream, fixed 2-cycle latency
module show_box_overlay #(
  parameter int P_W    = 11,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int LINE_W = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           i_valid,
  input  logic [23:0]    i_data,
  input  logic           i_sof,
  input  logic           box_wr,
  input  logic [1:0]     box_idx,
  input  logic           box_en,
  input  logic [P_W-1:0] box_x0,
  input  logic [P_W-1:0] box_y0,
  input  logic [P_W-1:0] box_x1,
  input  logic [P_W-1:0] box_y1,
  input  logic [23:0]    box_color,
  output logic           o_valid,
  output logic [23:0]    o_data,
  output logic           o_sof
);

  typedef struct packed {
    logic           en;
    logic [P_W-1:0] x0;
    logic [P_W-1:0] y0;
    logic [P_W-1:0] x1;
    logic [P_W-1:0] y1;
    logic [23:0]    color;
  } box_t;

  localparam logic [P_W-1:0] LW    = P_W'(LINE_W);
  localparam logic [P_W-1:0] X_MAX = P_W'(IMG_W - 1);
  localparam logic [P_W-1:0] Y_MAX = P_W'(IMG_H - 1);

  box_t [3:0]      shd_q, act_q, act_sel;
  logic [P_W-1:0]  cnt_x_q, cnt_y_q, cnt_x_d, cnt_y_d;
  logic [P_W-1:0]  pix_x, pix_y;
  logic            frame_start;
  logic [3:0]      hit;

  logic            s1_vld_q, s1_sof_q;
  logic [23:0]     s1_data_q;
  logic [3:0]      s1_hit_q;
  logic [3:0][23:0] s1_col_q;
  logic [23:0]     o_data_d;

  assign frame_start = i_valid && (i_sof || (cnt_x_q == '0 && cnt_y_q == '0));
  // i_sof forces the current pixel to the origin regardless of the counters.
  assign pix_x = i_sof ? '0 : cnt_x_q;
  assign pix_y = i_sof ? '0 : cnt_y_q;
  // The frame-start pixel must already see the boxes being loaded this cycle.
  // shd_q is the pre-write value, so a coincident box_wr lands next frame.
  assign act_sel = frame_start ? shd_q : act_q;

  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (i_valid) begin
      if (i_sof) begin
        cnt_x_d = P_W'(1);
        cnt_y_d = '0;
      end else if (cnt_x_q == X_MAX) begin
        cnt_x_d = '0;
        cnt_y_d = (cnt_y_q == Y_MAX) ? '0 : cnt_y_q + P_W'(1);
      end else begin
        cnt_x_d = cnt_x_q + P_W'(1);
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_box
    logic in_x, in_y, on_brd;
    assign in_x = (pix_x >= act_sel[k].x0) && (pix_x <= act_sel[k].x1);
    assign in_y = (pix_y >= act_sel[k].y0) && (pix_y <= act_sel[k].y1);
    // Differences only matter when inside the box, where they cannot wrap.
    assign on_brd = ((pix_x - act_sel[k].x0) < LW) || ((act_sel[k].x1 - pix_x) < LW) ||
                    ((pix_y - act_sel[k].y0) < LW) || ((act_sel[k].y1 - pix_y) < LW);
    assign hit[k] = act_sel[k].en && in_x && in_y && on_brd;
  end

  // Lowest index wins: scan from the top so box 0 is applied last.
  always_comb begin
    o_data_d = s1_data_q;
    for (int k = 3; k >= 0; k--) begin
      if (s1_hit_q[k]) o_data_d = s1_col_q[k];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
      shd_q     <= '0;
      act_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_data_q <= '0;
      s1_hit_q  <= '0;
      s1_col_q  <= '0;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_data    <= '0;
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      if (frame_start) act_q <= shd_q;
      if (box_wr) begin
        shd_q[box_idx].en    <= box_en;
        shd_q[box_idx].x0    <= box_x0;
        shd_q[box_idx].y0    <= box_y0;
        shd_q[box_idx].x1    <= box_x1;
        shd_q[box_idx].y1    <= box_y1;
        shd_q[box_idx].color <= box_color;
      end
      s1_vld_q  <= i_valid;
      s1_sof_q  <= i_valid & i_sof;
      s1_data_q <= i_data;
      s1_hit_q  <= hit;
      for (int k = 0; k < 4; k++) s1_col_q[k] <= act_sel[k].color;
      o_valid   <= s1_vld_q;
      o_sof     <= s1_sof_q;
      o_data    <= o_data_d;
    end
  end

endmodule

// File: tb/tb_show_box_overlay.sv
// Bench for show_box_overlay on a reduced 64x48 image. A pixel-level model
// (counters, shadow/active box lists, plain-integer hit test) predicts every
// output; a ring of per-edge expectations is checked 2 edges later. Literal
// probes at hand-picked pixels pin the model as well.
module tb_show_box_overlay;
  localparam int PW = 11, W = 64, H = 48, LW = 2;

  logic sys_clk = 1'b0, sys_rst = 1'b0;
  logic i_valid = 1'b0, i_sof = 1'b0, box_wr = 1'b0, box_en = 1'b0;
  logic [23:0] i_data = '0, box_color = '0;
  logic [1:0] box_idx = '0;
  logic [PW-1:0] box_x0 = '0, box_y0 = '0, box_x1 = '0, box_y1 = '0;
  logic o_valid, o_sof;
  logic [23:0] o_data;

  show_box_overlay #(.P_W(PW), .IMG_W(W), .IMG_H(H), .LINE_W(LW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_valid(i_valid), .i_data(i_data),
    .i_sof(i_sof), .box_wr(box_wr), .box_idx(box_idx), .box_en(box_en),
    .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
    .box_color(box_color), .o_valid(o_valid), .o_data(o_data), .o_sof(o_sof));

  always #5 sys_clk = ~sys_clk;

  typedef struct {bit en; int x0, y0, x1, y1; logic [23:0] c;} mbox_t;
  typedef struct {int f, x, y; logic [23:0] v;} probe_t;

  mbox_t shd[4], act[4];
  int mx = 0, my = 0, fnum = -1;

  bit e_set[8], e_rst[8], e_v[8], e_sof[8];
  logic [23:0] e_d[8];
  int e_x[8], e_y[8], e_f[8];
  int ecnt = 0;
  int n_cmp = 0, n_bad = 0;

  bit pend = 0; int pend_idx = 0; mbox_t pend_b;
  probe_t probes[$];
  int phit[64];

  localparam logic [23:0] C0 = 24'h123456, GRN = 24'h00FF00, MAG = 24'hFF00FF,
                          RED = 24'hFF0000, BLU = 24'h0000FF, CYN = 24'h00FFFF;

  function automatic bit mhit(mbox_t b, int x, int y);
    if (!b.en || x < b.x0 || x > b.x1 || y < b.y0 || y > b.y1) return 0;
    return (x - b.x0 < LW) || (b.x1 - x < LW) || (y - b.y0 < LW) || (b.y1 - y < LW);
  endfunction

  function automatic logic [23:0] model_pix(int x, int y, logic [23:0] d);
    for (int k = 0; k < 4; k++) if (mhit(act[k], x, y)) return act[k].c;
    return d;
  endfunction

  task automatic chk(string nm, logic [23:0] a, logic [23:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h expected %h (edge %0d)", nm, a, x, ecnt);
    end
  endtask

  // One input cycle: drive at negedge, record what the following edge implies.
  task automatic step(bit v, bit sof, logic [23:0] d, bit rst);
    int sl, px, py;
    @(negedge sys_clk);
    sys_rst = rst; i_valid = v; i_sof = sof; i_data = d; box_wr = pend;
    if (pend) begin
      box_idx = 2'(pend_idx); box_en = pend_b.en; box_color = pend_b.c;
      box_x0 = PW'(pend_b.x0); box_y0 = PW'(pend_b.y0);
      box_x1 = PW'(pend_b.x1); box_y1 = PW'(pend_b.y1);
    end
    sl = (ecnt + 1) % 8;
    e_set[sl] = 1; e_rst[sl] = rst; e_v[sl] = v && !rst; e_sof[sl] = v && sof && !rst;
    if (rst) begin
      mx = 0; my = 0;
      for (int k = 0; k < 4; k++) begin shd[k] = '{0, 0, 0, 0, 0, 24'h0}; act[k] = shd[k]; end
    end else begin
      if (v) begin
        px = sof ? 0 : mx; py = sof ? 0 : my;
        if (sof || (mx == 0 && my == 0)) begin act = shd; fnum++; end
        e_d[sl] = model_pix(px, py, d); e_x[sl] = px; e_y[sl] = py; e_f[sl] = fnum;
        if (sof) begin mx = 1; my = 0; end
        else if (mx == W - 1) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
        else mx++;
      end
      if (pend) shd[pend_idx] = pend_b;
    end
    pend = 0;
  endtask

  task automatic wr(int idx, bit en, int x0, int y0, int x1, int y1, logic [23:0] c);
    pend = 1; pend_idx = idx; pend_b = '{en, x0, y0, x1, y1, c};
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 24'h0, 0);
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) step(0, 0, 24'($urandom), 0);
  endtask

  task automatic frame(logic [23:0] d);
    for (int i = 0; i < W * H; i++) step(1, i == 0, d, 0);
  endtask

  task automatic probe(int f, int x, int y, logic [23:0] v);
    probe_t p;
    p = '{f, x, y, v};
    probes.push_back(p);
  endtask

  // Compare process: after edge n the outputs reflect the input captured at n-1.
  initial begin
    int s0, s1;
    forever begin
      @(posedge sys_clk);
      ecnt++;
      #1;
      s0 = ecnt % 8; s1 = (ecnt + 7) % 8;
      if (e_set[s0] && e_rst[s0]) begin
        chk("rst o_valid", {23'b0, o_valid}, 24'h0);
        chk("rst o_sof", {23'b0, o_sof}, 24'h0);
        chk("rst o_data", o_data, 24'h0);
      end else if (e_set[s1]) begin
        chk("o_valid", {23'b0, o_valid}, {23'b0, e_v[s1]});
        chk("o_sof", {23'b0, o_sof}, {23'b0, e_sof[s1]});
        if (e_rst[s1]) chk("post-rst o_data", o_data, 24'h0);
        else if (e_v[s1]) begin
          chk($sformatf("o_data f%0d(%0d,%0d)", e_f[s1], e_x[s1], e_y[s1]), o_data, e_d[s1]);
          foreach (probes[i])
            if (probes[i].f == e_f[s1] && probes[i].x == e_x[s1] && probes[i].y == e_y[s1]) begin
              chk($sformatf("probe f%0d(%0d,%0d)", probes[i].f, probes[i].x, probes[i].y),
                  o_data, probes[i].v);
              phit[i]++;
            end
        end
      end
    end
  end

  initial begin
    int i;
    foreach (phit[k]) phit[k] = 0;
    // single box
    probe(2, 10, 25, GRN); probe(2, 11, 25, GRN); probe(2, 12, 25, C0);
    probe(2, 20, 40, GRN); probe(2, 20, 39, GRN); probe(2, 20, 30, C0); probe(2, 31, 25, C0);
    // mid-frame write of a full-image border
    probe(3, 1, 1, C0); probe(3, 63, 47, C0);
    probe(4, 1, 1, MAG); probe(4, 2, 2, C0); probe(4, 63, 47, MAG);
    probe(4, 62, 10, MAG); probe(4, 61, 10, C0); probe(4, 10, 25, GRN);
    // priority / degenerate
    probe(5, 50, 10, RED); probe(5, 51, 10, BLU); probe(5, 49, 10, RED);
    probe(5, 48, 10, C0); probe(5, 55, 10, C0); probe(5, 40, 5, RED); probe(5, 45, 20, C0);
    // after resync at nominal (60,7)
    probe(7, 50, 10, RED); probe(7, 51, 10, BLU);
    // write on frame-start pixel
    probe(8, 10, 25, GRN); probe(8, 20, 25, C0);
    probe(9, 10, 25, C0); probe(9, 20, 25, GRN); probe(9, 21, 25, GRN); probe(9, 22, 25, C0);

    for (int k = 0; k < 3; k++) step(1, 0, 24'hABCDEF, 1);
    // frame 0: no i_sof, starts from counters; passthrough of a varying pattern
    for (int k = 0; k < W * H; k++) step(1, 0, {8'(mx), 8'(my), 8'hA5}, 0);
    idle(2);
    wr(0, 1, 10, 20, 30, 40, GRN); idle(3);
    frame(C0); frame(C0);
    for (int k = 0; k < W * H; k++) begin
      if (mx == 40 && my == 30) wr(1, 1, 0, 0, 63, 47, MAG);
      step(1, k == 0, C0, 0);
    end
    frame(C0);
    wr(0, 1, 30, 5, 50, 15, RED); step(0, 0, 0, 0);
    wr(1, 1, 50, 5, 60, 15, BLU); step(0, 0, 0, 0);
    wr(2, 1, 60, 0, 40, 47, CYN); step(0, 0, 0, 0);
    frame(C0);
    // gapped frame aborted by i_sof at nominal (60,7)
    i = 0;
    while (!(mx == 60 && my == 7) || i == 0) begin gap(); step(1, i == 0, C0, 0); i++; end
    for (int k = 0; k < W * H; k++) begin gap(); step(1, k == 0, C0, 0); end
    wr(0, 1, 10, 20, 30, 40, GRN); step(0, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 0, 24'h0); step(0, 0, 0, 0);
    wr(2, 0, 0, 0, 0, 0, 24'h0); step(0, 0, 0, 0);
    for (int k = 0; k < W * H; k++) begin
      if (k == 0) wr(0, 1, 20, 20, 30, 40, GRN);
      step(1, k == 0, C0, 0);
    end
    frame(C0);
    idle(4);
    foreach (probes[k]) begin
      n_cmp++;
      if (phit[k] != 1) begin
        n_bad++;
        $display("FAIL probe-seen f%0d(%0d,%0d): seen %0d times, expected 1",
                 probes[k].f, probes[k].x, probes[k].y, phit[k]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/show_box_overlay.md
Name: show_box_overlay

Overview:
- Pixel-stream stage placed directly downstream of the glyph overlay stage in the post-processing show_pic chain.
- Consumes its 24-bit RGB valid/data stream and draws up to four rectangular border boxes, e.g. detection frames for purchased items, with per-box colour.
- Box coordinates are programmed at any time but take effect only at frame boundaries, so a box never tears mid-frame.
- Output feeds the display/frame-buffer writer.

Parameters:
- P_W, 11, coordinate width in bits.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- LINE_W, 2, border thickness in pixels; valid range 1..8.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input pixel qualifier; may drop for any number of cycles (gaps).
- i_data  in  24  input RGB888 pixel.
- i_sof  in  1  start of frame; sampled only with i_valid; marks the pixel as (0,0).
- box_wr  in  1  one-cycle write strobe for the shadow box registers.
- box_idx  in  2  box selected by box_wr.
- box_en  in  1  enable bit written with box_wr.
- box_x0, box_y0, box_x1, box_y1  in  P_W each  inclusive box corners written with box_wr.
- box_color  in  24  border colour written with box_wr.
- o_valid  out  1  output pixel qualifier.
- o_data  out  24  output pixel.
- o_sof  out  1  i_sof delayed by the same latency, qualified by o_valid.

Behaviour:
Interface:
- One clock domain, sys_clk.
- Reset is synchronous and active-high (sys_rst): all state is cleared on the sys_clk edge where sys_rst=1.

Reset state:
- o_valid=0, o_data=0, o_sof=0.
- Pixel counters cnt_x=0, cnt_y=0.
- All shadow and active boxes: en=0, coordinates 0, colour 0.
- Reset mid-frame aborts the frame. Counting restarts at (0,0) with the next valid pixel, or at the next i_sof.

Pixel counters (advance only when i_valid=1):
- i_valid && i_sof: the current pixel is (0,0); after the pixel cnt_x=1, cnt_y=0.
- Otherwise, when cnt_x=IMG_W-1: cnt_x wraps to 0 and cnt_y increments; cnt_y wraps from IMG_H-1 to 0.
- Otherwise cnt_x increments.
- "Frame start pixel" means i_valid && (i_sof || (cnt_x==0 && cnt_y==0)).

Shadow and active boxes:
- box_wr writes shadow[box_idx] in one cycle.
- On a frame-start pixel, all four active boxes are loaded from shadow in that same cycle, and the frame-start pixel is evaluated with the NEW active values.
- Load logic must therefore compare against the shadow values on that cycle.
- box_wr coinciding with a frame-start pixel: the write lands in shadow. The frame being started uses the pre-write shadow value; the written value applies from the following frame.
- Writes elsewhere in a frame never affect the current frame.

Hit rule for box k:
- Box k hits pixel (x,y) iff all of:
  - en=1.
  - x0<=x<=x1 and y0<=y<=y1.
  - At least one of x-x0<LINE_W, x1-x<LINE_W, y-y0<LINE_W, y1-y<LINE_W.
- All compares are unsigned at P_W bits. The differences are only formed inside the range, so they cannot underflow.
- Degenerate box (x0>x1 or y0>y1): never hits.
- Box narrower than 2*LINE_W: filled solid.
- Coordinates beyond IMG_W/IMG_H: legal; simply never reached.
- Overlapping boxes: the lowest index wins (box 0 highest priority).

Pipeline (latency exactly 2 cycles, valid or not):
- Stage 1 registers i_valid, i_sof, i_data and the four hit flags together with their colours.
- Stage 2 registers o_data = colour of the highest-priority hit box, else the delayed i_data. o_valid and o_sof are the 2-cycle-delayed i_valid and i_sof.
- When stage-1 valid=0, o_data is still updated; downstream must ignore it while o_valid=0.
- No backpressure: one pixel in per cycle maximum, one pixel out.

Test Plan:
- Reset: hold sys_rst 3 cycles during streaming -> o_valid=0, o_data=0, o_sof=0; first frame after release passes i_data unchanged (no boxes enabled).
- Single box: write idx0 (10,20)-(30,40), colour 24'h00FF00, en=1, then stream 2 frames of constant 24'h123456 -> in frame 2, (10,25) and (11,25) =00FF00; (12,25)=123456; (20,40) and (20,39)=00FF00; (20,30)=123456; output exactly 2 cycles after input.
- Mid-frame write: in frame N at pixel (100,100), write idx1 (0,0)-(639,479), en=1 -> frame N unchanged; frame N+1 has a 2-pixel border around the full image.
- Priority/degenerate: box0 red and box1 blue sharing the edge x=50; box2 with x0=60>x1=40 -> shared-edge pixels red; box2 never appears.
- Resync and gaps: random i_valid gaps of 0..5 cycles, plus i_sof asserted at nominal pixel (300,7) -> counters restart there; o_sof appears 2 cycles later with o_valid; box positions relative to the new origin.
- Write on frame-start cycle: box_wr with the frame-start pixel changes box0 x0 from 10 to 200 -> that frame draws at x0=10; the next frame draws at x0=200.
